// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI4-Stream round-robin arbiters.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // Width of the per-packet beat watchdog counter.
    localparam int ARB_CNT_W   = 16;
    // Widest requester vector the round-robin helper handles.
    localparam int ARB_MAX_REQ = 8;

    // Returns the first requester at or after index (last+1) mod n whose
    // request bit is set. If no bit is set, 'last' is returned unchanged.
    function automatic logic [2:0] rr_pick(
        input logic [ARB_MAX_REQ-1:0] req,
        input logic [2:0]             last,
        input int                     n
    );
        logic [2:0] sel;
        logic       found;
        int         idx;
        sel   = last;
        found = 1'b0;
        for (int off = 1; off <= ARB_MAX_REQ; off++) begin
            if (off <= n) begin
                idx = (int'(last) + off) % n;
                if (!found && req[idx[2:0]]) begin
                    sel   = 3'(idx);
                    found = 1'b1;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational round-robin priority encoder: picks the first set request
// strictly after the previously served index, wrapping around.
module rr_pick_comb
    import axis_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] pick_o,
    output logic          any_o
);

    logic [ARB_MAX_REQ-1:0] req_ext;

    // Zero-extend the request vector to the helper's fixed width.
    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req_i;
    end

    assign pick_o = IW'(rr_pick(req_ext, 3'(last_i), N));
    assign any_o  = |req_i;

endmodule

// File: rtl/axis_cmd_rr_arb.sv
// Packet-granular round-robin arbiter for the shared DMA command stream.
// The grant is taken in IDLE and held until the beat carrying tlast.
`ifndef AXI4S_DATA_WIDTH
`define AXI4S_DATA_WIDTH 64
`endif
`ifndef AXI4S_KEEP_WIDTH
`define AXI4S_KEEP_WIDTH 8
`endif
`ifndef AXI4S_USER_WIDTH
`define AXI4S_USER_WIDTH 1
`endif

module axis_cmd_rr_arb
    import axis_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DWIDTH    = `AXI4S_DATA_WIDTH,
    parameter int KWIDTH    = `AXI4S_KEEP_WIDTH,
    parameter int UWIDTH    = `AXI4S_USER_WIDTH,
    parameter int MAX_BEATS = 64,
    localparam int IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        s_tvalid,
    output logic [NUM_REQ-1:0]        s_tready,
    input  logic [NUM_REQ*DWIDTH-1:0] s_tdata,
    input  logic [NUM_REQ*KWIDTH-1:0] s_tkeep,
    input  logic [NUM_REQ*UWIDTH-1:0] s_tuser,
    input  logic [NUM_REQ-1:0]        s_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [DWIDTH-1:0]         m_tdata,
    output logic [KWIDTH-1:0]         m_tkeep,
    output logic [UWIDTH-1:0]         m_tuser,
    output logic                      m_tlast,
    input  logic [NUM_REQ-1:0]        req_en,
    output logic [IW-1:0]             cur_grant,
    output logic                      busy,
    output logic                      pkt_err,
    input  logic                      err_clr
);

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [IW-1:0]        last_q, last_d;
    logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [NUM_REQ-1:0]   cand;
    logic [IW-1:0]        pick;
    logic                 any_cand;
    logic                 sel_valid, sel_last, beat, wd_hit;

    // The mask is only consulted while idle; a running packet ignores it.
    assign cand = s_tvalid & req_en;

    rr_pick_comb #(
        .N (NUM_REQ)
    ) u_pick (
        .req_i  (cand),
        .last_i (last_q),
        .pick_o (pick),
        .any_o  (any_cand)
    );

    // Zero-latency data path: everything muxed from the registered grant.
    assign sel_valid = s_tvalid[grant_q];
    assign sel_last  = s_tlast[grant_q];
    assign m_tdata   = s_tdata[grant_q*DWIDTH +: DWIDTH];
    assign m_tkeep   = s_tkeep[grant_q*KWIDTH +: KWIDTH];
    assign m_tuser   = s_tuser[grant_q*UWIDTH +: UWIDTH];
    assign m_tlast   = sel_last;
    assign beat      = m_tvalid & m_tready;

    // Ready is routed back only to the granted requester, only while busy.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign s_tready[gi] = busy & (grant_q == IW'(gi)) & m_tready;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic: leave IDLE on any candidate, leave XFER on tlast beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_cand)         state_d = XFER;
            XFER:    if (beat && sel_last) state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy     = (state_q == XFER);
        m_tvalid = busy & sel_valid;
    end

    // Grant capture, round-robin pointer update and saturating beat watchdog.
    always_comb begin
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        wd_hit  = 1'b0;
        if (state_q == IDLE && any_cand) begin
            grant_d = pick;
        end
        if (beat) begin
            if (sel_last) begin
                last_d = grant_q;
                cnt_d  = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            wd_hit = !sel_last && (({1'b0, cnt_q} + 17'd1) == 17'(MAX_BEATS));
        end
        // A new violation in the same cycle as a clear keeps the flag set.
        err_d = wd_hit ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign cur_grant = grant_q;
    assign pkt_err   = err_q;

endmodule

// File: tb/tb_axis_cmd_rr_arb.sv
// Directed testbench for axis_cmd_rr_arb (4 requesters, 8-bit data).
module tb_axis_cmd_rr_arb;

    logic        clk, rst;
    logic [3:0]  s_tvalid, s_tready, s_tlast, s_tkeep, req_en;
    logic [31:0] s_tdata;
    logic [7:0]  s_tuser;
    logic        m_tvalid, m_tready, m_tlast, m_tkeep;
    logic [7:0]  m_tdata;
    logic [1:0]  m_tuser, cur_grant;
    logic        busy, pkt_err, err_clr;

    axis_cmd_rr_arb #(
        .NUM_REQ(4), .DWIDTH(8), .KWIDTH(1), .UWIDTH(2), .MAX_BEATS(64)
    ) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tlast(m_tlast),
        .req_en(req_en), .cur_grant(cur_grant), .busy(busy),
        .pkt_err(pkt_err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Source models: beats left in the current packet, packets still queued.
    int         src_left[4];
    int         src_pkts[4];
    int         src_len[4];
    logic [7:0] src_data[4];
    logic [7:0] src_step[4];
    logic [3:0] hs_cap;
    logic       mrdy_next, clr_next;

    // Master-side log of accepted beats.
    logic [7:0] log_data[$];
    logic       log_last[$];
    int         log_grant[$];
    int         log_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < 4; i++) begin
            s_tvalid[i]        = (src_left[i] > 0);
            s_tdata[i*8 +: 8]  = src_data[i];
            s_tlast[i]         = (src_left[i] == 1);
            s_tkeep[i]         = 1'b1;
            s_tuser[i*2 +: 2]  = 2'(i);
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            src_left[i] = 0; src_pkts[i] = 0; src_len[i] = 0;
            src_data[i] = 8'h00; src_step[i] = 8'h01;
        end
    endtask

    task automatic load_src(input int i, input int npkts, input int len,
                            input logic [7:0] d0, input logic [7:0] stp);
        src_left[i] = len; src_pkts[i] = npkts - 1; src_len[i] = len;
        src_data[i] = d0;  src_step[i] = stp;
    endtask

    // One clock cycle: log the beat at the falling edge, update sources after
    // the rising edge, leave the bench settled inside the new cycle.
    task automatic step();
        @(negedge clk);
        hs_cap = s_tvalid & s_tready;
        if (m_tvalid && m_tready) begin
            log_data.push_back(m_tdata);
            log_last.push_back(m_tlast);
            log_grant.push_back(int'(cur_grant));
            log_cyc.push_back(cyc);
            $display("beat cyc=%0d grant=%0d data=%02h last=%0b", cyc, cur_grant, m_tdata, m_tlast);
        end
        @(posedge clk);
        #1;
        cyc++;
        m_tready = mrdy_next;
        err_clr  = clr_next;
        clr_next = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (hs_cap[i]) begin
                src_data[i] = src_data[i] + src_step[i];
                src_left[i]--;
                if (src_left[i] == 0 && src_pkts[i] > 0) begin
                    src_pkts[i]--;
                    src_left[i] = src_len[i];
                end
            end
        end
        drive_src();
        #1;
    endtask

    task automatic wait_beats(input int n, input int bound);
        int k;
        k = 0;
        while (log_data.size() < n && k < bound) begin
            step();
            k++;
        end
        if (log_data.size() < n) check("beat_timeout", log_data.size(), n);
    endtask

    task automatic clear_log();
        log_data.delete(); log_last.delete(); log_grant.delete(); log_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_src();
        drive_src();
        m_tready = 1'b1; mrdy_next = 1'b1;
        err_clr = 1'b0;  clr_next = 1'b0;
        req_en = 4'b1111;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        clear_log();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, err_at, bad;
        logic [7:0] t2_data[10];
        int         t2_grant[10];
        int         t3b_grant[9];
        logic       pat[6];
        logic [7:0] t4_exp[6];

        t2_data   = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
        t2_grant  = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        t3b_grant = '{1, 1, 1, 3, 3, 3, 3, 3, 3};
        pat       = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        t4_exp    = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03};

        // ---------------- reset state ----------------
        do_reset();
        check("rst_tready", s_tready, 4'b0000);
        check("rst_mvalid", m_tvalid, 1'b0);
        check("rst_busy",   busy,     1'b0);
        check("rst_grant",  cur_grant, 2'd0);
        check("rst_err",    pkt_err,  1'b0);

        // ---------------- T1: requester 2, 3 beats ----------------
        load_src(2, 1, 3, 8'h11, 8'h11);
        drive_src();
        #1;
        c0 = cyc;
        check("t1_idle_tready", s_tready, 4'b0000);
        check("t1_idle_busy",   busy,     1'b0);
        step();
        check("t1_grant",  cur_grant, 2'd2);
        check("t1_mvalid", m_tvalid,  1'b1);
        check("t1_mdata",  m_tdata,   8'h11);
        check("t1_muser",  m_tuser,   2'd2);
        check("t1_tready", s_tready,  4'b0100);
        wait_beats(3, 20);
        if (log_data.size() >= 3) begin
            check("t1_d0", log_data[0], 8'h11);
            check("t1_d1", log_data[1], 8'h22);
            check("t1_d2", log_data[2], 8'h33);
            check("t1_lasts", {log_last[0], log_last[1], log_last[2]}, 3'b001);
            check("t1_lat",   log_cyc[0], c0 + 1);
            check("t1_busy_drop_cyc", cyc, log_cyc[2] + 1);
        end
        check("t1_busy_after", busy, 1'b0);

        // ---------------- T2: all four requesters, 2-beat packets ----------------
        do_reset();
        load_src(0, 2, 2, 8'h00, 8'h01);
        load_src(1, 1, 2, 8'h10, 8'h01);
        load_src(2, 1, 2, 8'h20, 8'h01);
        load_src(3, 1, 2, 8'h30, 8'h01);
        drive_src();
        #1;
        wait_beats(10, 60);
        if (log_data.size() >= 10) begin
            bad = 0;
            for (int i = 0; i < 10; i++) begin
                if (log_data[i] !== t2_data[i] || log_grant[i] != t2_grant[i]) bad++;
            end
            check("t2_order", bad, 0);
            for (int k = 1; k < 5; k++) check("t2_bubble", log_cyc[2*k] - log_cyc[2*k-1], 2);
            check("t2_inpkt", log_cyc[9] - log_cyc[8], 1);
        end

        // ---------------- T3a: mask 1010, only 1 and 3 alternate ----------------
        do_reset();
        req_en = 4'b1010;
        for (int i = 0; i < 4; i++) load_src(i, 2, 2, 8'(i * 16), 8'h01);
        drive_src();
        #1;
        wait_beats(8, 60);
        repeat (5) step();
        check("t3a_count", log_data.size(), 8);
        if (log_data.size() >= 8) begin
            check("t3a_grants", {2'(log_grant[0]), 2'(log_grant[2]), 2'(log_grant[4]), 2'(log_grant[6])},
                  {2'd1, 2'd3, 2'd1, 2'd3});
        end
        check("t3a_idle", busy, 1'b0);

        // ---------------- T3b: clearing req_en[1] mid-packet ----------------
        do_reset();
        req_en = 4'b1010;
        load_src(1, 2, 3, 8'h40, 8'h01);
        load_src(3, 2, 3, 8'h60, 8'h01);
        drive_src();
        #1;
        wait_beats(1, 10);
        req_en = 4'b1000;
        wait_beats(9, 80);
        repeat (5) step();
        check("t3b_count", log_data.size(), 9);
        if (log_data.size() >= 9) begin
            bad = 0;
            for (int i = 0; i < 9; i++) if (log_grant[i] != t3b_grant[i]) bad++;
            check("t3b_grants", bad, 0);
            check("t3b_req1_last", {log_data[2], 7'd0, log_last[2]}, {8'h42, 7'd0, 1'b1});
        end

        // ---------------- T4: m_tready backpressure ----------------
        do_reset();
        for (int i = 0; i < 4; i++) load_src(i, 1, 4, 8'(i * 16), 8'h01);
        drive_src();
        #1;
        for (int k = 0; k < 6; k++) begin
            mrdy_next = pat[k];
            step();
            check("t4_other_tready", s_tready & 4'b1110, 4'b0000);
            check("t4_mdata", m_tdata, t4_exp[k]);
        end
        mrdy_next = 1'b1;
        wait_beats(4, 10);
        if (log_data.size() >= 4) begin
            check("t4_beats", {log_data[0], log_data[1], log_data[2], log_data[3]}, 32'h00010203);
            check("t4_lasts", {log_last[0], log_last[1], log_last[2], log_last[3]}, 4'b0001);
            check("t4_grant", log_grant[3], 0);
        end

        // ---------------- T5: watchdog with 70-beat packet ----------------
        do_reset();
        load_src(0, 1, 70, 8'h00, 8'h01);
        drive_src();
        #1;
        err_at = -1;
        for (int g = 0; g < 200 && log_data.size() < 70; g++) begin
            step();
            if (pkt_err && err_at < 0) err_at = log_data.size();
        end
        check("t5_count", log_data.size(), 70);
        check("t5_err_at", err_at, 64);
        if (log_data.size() >= 70) begin
            bad = 0;
            for (int i = 0; i < 70; i++) begin
                if (log_data[i] !== 8'(i) || log_last[i] !== (i == 69)) bad++;
            end
            check("t5_data", bad, 0);
        end
        check("t5_busy", busy, 1'b0);
        check("t5_sticky", pkt_err, 1'b1);
        clr_next = 1'b1;
        step();
        check("t5_clr_pending", pkt_err, 1'b1);
        step();
        check("t5_cleared", pkt_err, 1'b0);

        // ---------------- T6: reset during beat 2 ----------------
        do_reset();
        load_src(2, 1, 5, 8'hA0, 8'h01);
        drive_src();
        #1;
        wait_beats(1, 10);
        check("t6_beat2_valid", m_tvalid, 1'b1);
        check("t6_beat2_data",  m_tdata,  8'hA1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_mvalid", m_tvalid, 1'b0);
        check("t6_rst_busy",   busy,     1'b0);
        check("t6_rst_tready", s_tready, 4'b0000);
        clear_src();
        load_src(0, 1, 2, 8'h50, 8'h01);
        load_src(2, 1, 2, 8'hB0, 8'h01);
        drive_src();
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        clear_log();
        wait_beats(2, 20);
        if (log_data.size() >= 2) begin
            check("t6_first_grant", log_grant[0], 0);
            check("t6_first_data",  log_data[0],  8'h50);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_cmd_rr_arb.md
# axis_cmd_rr_arb

Packet-granular round-robin arbiter that shares the single DMA master AXI4-Stream command channel (Channel A command, AXI4S widths) among `NUM_REQ` requesters. Sits between the user-logic command sources and the shell command port. A grant is held from first beat to `tlast`. Includes a per-packet beat watchdog and per-requester enable mask.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `DWIDTH`, `` `AXI4S_DATA_WIDTH ``: tdata width.
- `KWIDTH`, `` `AXI4S_KEEP_WIDTH ``: tkeep width.
- `UWIDTH`, `` `AXI4S_USER_WIDTH ``: tuser width.
- `MAX_BEATS`, 64: beat count at which a packet without `tlast` is flagged.

Ports:
- `clk`  in  1  single clock; every signal is synchronous to it.
- `rst`  in  1  asynchronous, active-low reset.
- `s_tvalid`  in  NUM_REQ  per-requester valid.
- `s_tready`  out  NUM_REQ  per-requester ready.
- `s_tdata`  in  NUM_REQ*DWIDTH  flattened; requester i occupies slice [i*DWIDTH +: DWIDTH].
- `s_tkeep`  in  NUM_REQ*KWIDTH  flattened, same slicing rule.
- `s_tuser`  in  NUM_REQ*UWIDTH  flattened, same slicing rule.
- `s_tlast`  in  NUM_REQ  per-requester last.
- `m_tvalid` / `m_tready` / `m_tdata` / `m_tkeep` / `m_tuser` / `m_tlast`  out/in/out/out/out/out  1/1/DWIDTH/KWIDTH/UWIDTH/1  shared command channel.
- `req_en`  in  NUM_REQ  requester enable mask; 0 excludes the requester from arbitration.
- `cur_grant`  out  $clog2(NUM_REQ)  index of the granted requester (valid only in XFER).
- `busy`  out  1  high in XFER.
- `pkt_err`  out  1  sticky watchdog flag.
- `err_clr`  in  1  single-cycle pulse that clears `pkt_err`.

## Operation
- FSM states: IDLE, XFER.
- IDLE:
  - Candidates are `s_tvalid & req_en`.
  - If any candidate exists, select the first one at or after index `(last+1) mod NUM_REQ`. Register it into `grant` and move to XFER.
  - Otherwise stay in IDLE.
  - All `s_tready` and `m_tvalid` are 0 in IDLE.
- XFER:
  - `m_t*` are driven combinationally from the slice selected by `grant`.
  - `s_tready[grant] = m_tready`; every other `s_tready` is 0.
  - A beat is transferred when `m_tvalid & m_tready`.
  - On a beat with `m_tlast=1`: `last <= grant`, clear the beat counter, go to IDLE.
- Mask changes during XFER have no effect until the next IDLE.
- If the granted requester deasserts valid mid-packet, `m_tvalid` drops and the grant is held. There is no timeout on valid.
- Watchdog:
  - 16-bit beat counter increments on each transferred beat.
  - When a beat without `tlast` makes the count equal `MAX_BEATS`, set `pkt_err`.
  - Transfer continues unmodified; the packet is not truncated.
  - The counter saturates and does not wrap.
- `err_clr` is evaluated against the set condition in the same cycle; if both occur together, set wins.
- `last` resets to `NUM_REQ-1`, so requester 0 wins the first arbitration.

## Timing
- Reset values: state=IDLE, `grant`=0, `last`=NUM_REQ-1, beat counter=0, `pkt_err`=0. Consequently `s_tready`=0, `m_tvalid`=0, `busy`=0, `cur_grant`=0.
- Arbitration latency:
  - First beat can be accepted 1 cycle after `s_tvalid` is seen in IDLE.
  - 1 idle bubble cycle between consecutive packets.
- Data path has 0 cycles of latency: combinational mux from the registered `grant`; no combinational path from `s_tvalid` to `s_tready`.
- Single-beat packet (`tlast` on the first beat): XFER lasts 1 cycle if `m_tready=1`.
- Reset asserted mid-packet: the FSM returns to IDLE immediately and the packet is abandoned. Recovery is the sink's responsibility.
- AXI4-Stream rule: once `m_tvalid` is high it stays high with stable data until `m_tready`, provided the granted source obeys the same rule.

## Structure
- Shared package `axis_arb_pkg`:
  - FSM state enum `arb_state_e` {IDLE, XFER}.
  - Constant `ARB_CNT_W = 16`.
  - Function `rr_pick(req, last)` returning the next index.
- One natural sub-module, `rr_pick_comb`: a combinational round-robin priority encoder. It is reusable by future data-channel arbiters.
- The top level holds the FSM, the mux, and the watchdog.

## Test plan
- Reset, then requester 2 sends a 3-beat packet (`tdata` 0x11/0x22/0x33) -> grant=2 one cycle after valid. Master sees the 3 beats in order with `tlast` on 0x33; `busy` drops the next cycle.
- All 4 requesters hold 2-beat packets continuously -> packets emerge in grant order 0,1,2,3,0. Exactly 1 bubble cycle between packets.
- `req_en`=4'b1010 with all valid -> only 1 and 3 alternate. Clearing `req_en[1]` mid-packet of requester 1 still completes that packet.
- `m_tready` toggles 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated, and `s_tready` of non-granted requesters stays 0 throughout.
- `MAX_BEATS`=64, requester 0 sends 70 beats with `tlast` on beat 70 -> `pkt_err` rises after beat 64 and all 70 beats pass. `err_clr` then returns `pkt_err` to 0.
- Assert `rst` low during beat 2 of a 5-beat packet -> the next cycle shows `m_tvalid`=0 and `busy`=0. After release, requester 0 wins first.
